// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter feeding a 4-bit ALU; optional rsp_zero/rsp_carry under ALU_ARBITER_FLAGS_EN.
// Latency: rsp_valid rises 2 clocks after the accept edge; accept-to-accept spacing is at least 3 cycles.
// Backpressure: response held in RESP until rsp_ready; no requester is readied until the response retires.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
`ifdef ALU_ARBITER_FLAGS_EN
  output logic       rsp_zero,
  output logic       rsp_carry,
`endif
  output logic       busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_q;
  logic       id_q;
  logic [2:0] op_q;
  logic [3:0] a_q, b_q;
  logic       grant_vld;
  logic       grant_id;
  logic [3:0] alu_res;

  always_comb begin
    state_d    = state_q;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Under contention the pointer picks whoever did not win last time.
        if (!rst) begin
          if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_q;
          end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
          end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
          end
        end
        if (grant_vld) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_res = 4'b0000;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_NOT:  alu_res = ~a_q;
      default: alu_res = 4'b0000;
    endcase
  end

`ifdef ALU_ARBITER_FLAGS_EN
  logic       alu_carry;
  logic [4:0] add_wide;

  always_comb begin
    add_wide  = {1'b0, a_q} + {1'b0, b_q};
    alu_carry = 1'b0;
    if (op_q == OP_ADD) alu_carry = add_wide[4];
    else if (op_q == OP_SUB) alu_carry = (a_q < b_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_zero  <= (alu_res == 4'b0000);
      rsp_carry <= alu_carry;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= 3'b000;
      a_q        <= 4'b0000;
      b_q        <= 4'b0000;
      rsp_id     <= 1'b0;
      rsp_result <= 4'b0000;
    end else begin
      state_q <= state_d;
      // Operands are sampled only on the accept cycle.
      if (grant_vld) begin
        last_q <= grant_id;
        id_q   <= grant_id;
        op_q   <= grant_id ? req1_op : req0_op;
        a_q    <= grant_id ? req1_a  : req0_a;
        b_q    <= grant_id ? req1_b  : req0_b;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_res;
        rsp_id     <= id_q;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level model of alu_arbiter.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_result;
`ifdef ALU_ARBITER_FLAGS_EN
  logic       rsp_zero, rsp_carry;
`endif

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
`ifdef ALU_ARBITER_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one operation in flight, response visible from 2 cycles after accept.
  bit         m_pending = 1'b0;
  int         m_acc = 0;
  int         cyc = 0;
  bit         m_last = 1'b1;
  logic       m_id;
  logic [3:0] m_res;
  logic       m_carry;
  logic       g_acc;
  logic       g_acc_id;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    case (op)
      3'd0: s = int'(a) + int'(b);
      3'd1: s = int'(a) - int'(b);
      3'd2: s = int'(a & b);
      3'd3: s = int'(a | b);
      3'd4: s = 15 - int'(a);
      default: s = 0;
    endcase
    return s[3:0];
  endfunction

  function automatic logic ref_carry(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (op == 3'd0) return (int'(a) + int'(b)) > 15;
    if (op == 3'd1) return int'(a) < int'(b);
    return 1'b0;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model, cross the edge.
  task automatic step(input logic v0, input logic [2:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic v1, input logic [2:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                      input logic rr);
    logic g_vld, g_id, exp_rv;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    g_vld  = !rst && !m_pending && (v0 || v1);
    g_id   = (v0 && v1) ? !m_last : v1;
    exp_rv = m_pending && (cyc - m_acc >= 2);
    chk1("req0_ready", req0_ready, g_vld && !g_id);
    chk1("req1_ready", req1_ready, g_vld && g_id);
    chk1("rsp_valid", rsp_valid, exp_rv);
    chk1("busy", busy, m_pending);
    if (exp_rv) begin
      chk1("rsp_id", rsp_id, m_id);
      chk4("rsp_result", rsp_result, m_res);
`ifdef ALU_ARBITER_FLAGS_EN
      chk1("rsp_zero", rsp_zero, m_res == 4'd0);
      chk1("rsp_carry", rsp_carry, m_carry);
`endif
    end
    g_acc    = g_vld;
    g_acc_id = g_id;
    if (rst) begin
      m_pending = 1'b0;
      m_last    = 1'b1;
    end else if (g_vld) begin
      m_pending = 1'b1;
      m_acc     = cyc;
      m_id      = g_id;
      m_res     = g_id ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
      m_carry   = g_id ? ref_carry(o1, a1, b1) : ref_carry(o0, a0, b0);
      m_last    = g_id;
    end else if (exp_rv && rr) begin
      m_pending = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0, rr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 3'd0, 4'd1, 4'd1, 1'b1, 3'd0, 4'd2, 4'd2, 1'b1);
    rst = 1'b0;
  endtask

  logic [3:0] sweep_exp [8] = '{4'b0000, 4'b0100, 4'b0010, 4'b1110, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
  logic [31:0] r;
  int k;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_rsp_id", rsp_id, 1'b0);
    chk4("reset_rsp_result", rsp_result, 4'd0);
    chk1("reset_busy", busy, 1'b0);
    do_reset();

    // Single request: ADD 3+4 from req0.
    step(1'b1, 3'd0, 4'd3, 4'd4, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    chk1("single_accept", g_acc, 1'b1);
    chk1("single_grant", g_acc_id, 1'b0);
    idle(1'b0);
    chk1("single_rsp_valid_t2", rsp_valid, 1'b1);
    chk1("single_rsp_id", rsp_id, 1'b0);
    chk4("single_rsp_result", rsp_result, 4'b0111);
    idle(1'b1);

    // Contention right after reset: grants alternate starting with req0.
    do_reset();
    k = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 3'd0, 4'd1, 4'd1, 1'b1, 3'd1, 4'd7, 4'd2, 1'b1);
      if (g_acc) begin
        chk1("contention_id", g_acc_id, k[0]);
        k++;
      end
    end
    chk4("contention_count", k[3:0], 4'd4);

    // Backpressure: response held 5 cycles while both requesters wait.
    do_reset();
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 3'd3, 4'd5, 4'd9, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd0, 4'd1, 4'd2, 1'b1, 3'd0, 4'd3, 4'd4, 1'b0);
      chk4("bp_result_stable", rsp_result, 4'b1101);
    end
    idle(1'b1);
    chk1("bp_idle_busy", busy, 1'b0);
    chk1("bp_idle_rsp_valid", rsp_valid, 1'b0);

    // Opcode sweep with A=1010, B=0110.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 4'b1010, 4'b0110, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
      idle(1'b0);
      chk4("sweep_result", rsp_result, sweep_exp[i]);
`ifdef ALU_ARBITER_FLAGS_EN
      if (i == 0) begin
        chk1("sweep_add_carry", rsp_carry, 1'b1);
        chk1("sweep_add_zero", rsp_zero, 1'b1);
      end
`endif
      idle(1'b1);
    end

    // Reset during EXEC after a req0 grant: op discarded and pointer restored.
    do_reset();
    step(1'b1, 3'd0, 4'd2, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk1("rst_exec_busy", busy, 1'b0);
    chk1("rst_exec_rsp_valid", rsp_valid, 1'b0);
    chk4("rst_exec_rsp_result", rsp_result, 4'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 3'd2, 4'd6, 4'd3, 1'b1, 3'd3, 4'd1, 4'd8, 1'b1);
    chk1("rst_exec_accept", g_acc, 1'b1);
    chk1("rst_exec_grant", g_acc_id, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic, including inputs changing mid-flight and requests dropped before grant.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = $urandom;
      step(r[0], r[3:1], r[7:4], r[11:8], r[12], r[15:13], r[19:16], r[23:20], r[24] | r[25]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
REQ-002 The module SHALL have these requester-0 ports:
- req0_valid  input  1  request 0 pending.
- req0_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, others zero.
- req0_a  input  4  operand A.
- req0_b  input  4  operand B.
- req0_ready  output  1  request 0 accepted this cycle.
REQ-003 Requester 1 SHALL have ports req1_valid, req1_op, req1_a, req1_b and req1_ready, identical to REQ-002.
REQ-004 The module SHALL have these response and status ports:
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that owns the response.
- rsp_result  output  4  4-bit ALU result.
- busy  output  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-006 IDLE behaviour:
- With no valid request, the FSM SHALL stay in IDLE.
- Otherwise the FSM SHALL grant one requester, assert its ready combinationally in that cycle, capture its op, a, b and id, and go to EXEC.
REQ-007 req0_ready and req1_ready SHALL be asserted only in IDLE, and never both in the same cycle.
REQ-008 When exactly one request is valid, that requester SHALL be granted.
REQ-009 When both requests are valid, the requester not granted last SHALL be granted (round-robin).
REQ-010 The last-grant pointer SHALL update only on accept.
REQ-011 In EXEC, the FSM SHALL compute the result from the captured operands, register it into rsp_result and rsp_id, and go to RESP.
REQ-012 Arithmetic SHALL be modulo 16, with the carry or borrow dropped; for example, ADD 1111+0001 = 0000 and SUB 0000-0001 = 1111.
REQ-013 NOT SHALL ignore B, and opcodes 101, 110 and 111 SHALL yield 0000.
REQ-014 In RESP, rsp_valid SHALL be 1 and rsp_id and rsp_result SHALL be held stable until rsp_ready is 1.
REQ-015 In RESP with rsp_ready = 1, the FSM SHALL return to IDLE.
REQ-016 A new request SHALL NOT be accepted in the cycle the response retires; the minimum accept-to-accept spacing SHALL be 3 cycles.
REQ-017 Latency SHALL be fixed: rsp_valid rises exactly 2 clocks after the accept edge.
REQ-018 Requester inputs SHALL be sampled only on the accept cycle, so changes afterwards have no effect on the in-flight operation.
REQ-019 A requester that drops valid before being granted SHALL lose its turn without error.

Reset
REQ-020 While rst = 1 at a clock edge, the module SHALL apply these reset values:
- State = IDLE.
- rsp_valid = 0, rsp_id = 0, rsp_result = 0000 and busy = 0.
- The last-grant pointer SHALL be set to 1, so that requester 0 wins the first contention.
REQ-021 Reset asserted mid-operation (in EXEC or RESP) SHALL discard the in-flight operation, and no response SHALL be issued for it.
REQ-022 While rst = 1, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-023 With macro ALU_ARBITER_FLAGS_EN defined, the module SHALL add two output ports, each 1 bit wide:
- rsp_zero: 1 when rsp_result = 0000.
- rsp_carry: the carry-out for ADD or the borrow for SUB, 0 for all other opcodes.
REQ-024 rsp_zero and rsp_carry SHALL be registered with rsp_result, reset to 0, and be held during RESP.
REQ-025 Without ALU_ARBITER_FLAGS_EN, the flag ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single request: req0 ADD 0011+0100 accepted at cycle t -> rsp_valid at t+2, rsp_id = 0, rsp_result = 0111.
- Contention after reset: both requests valid -> req0 granted first, req1 granted at the next IDLE, rsp_id sequence 0, 1, 0, 1 while both stay valid.
- Backpressure: rsp_ready held at 0 for 5 cycles in RESP -> rsp_result stable, both readys 0, return to IDLE the cycle after rsp_ready = 1.
- Opcode sweep: A = 1010, B = 0110 -> ADD 0000, SUB 0100, AND 0010, OR 1110, NOT 0101, and 0000 for opcodes 101, 110 and 111; with ALU_ARBITER_FLAGS_EN, ADD gives carry 1 and zero 1.
- Reset in EXEC -> next cycle state IDLE and busy = 0, with no rsp_valid pulse, and req0 wins the next contention.
